axis_weight_mult_pipe: RTL and testbench
========================================

// Module: axis_weight_mult_pipe
// PURPOSE
//  Parametrised successor to the single-weight stream scaler: multiplies every lane of an
//  AXI-Stream beat by one signed fixed-point beam weight. Registered 2-stage pipeline with
//  full ready/valid backpressure, round-half-up scaling, tkeep/tlast passthrough.
//  Weight is captured per packet. Sits between the ADC/DMA MM2S stream and the S2MM writer.
// PARAMETERS
//  NUM_LANES  16  samples per beat
//  SAMPLE_W   8   signed sample width (bits)
//  WEIGHT_W   8   signed weight width, Q1.(WEIGHT_W-1): 0x40 = +0.5, 0x80 = -1.0
// PORTS
//  CLK            in   1                    single clock, all logic rising-edge
//  RESETN         in   1                    asynchronous assert, active-low reset
//  s_axis_tdata   in   NUM_LANES*SAMPLE_W   input samples, lane k = [k*SAMPLE_W +: SAMPLE_W]
//  s_axis_tkeep   in   NUM_LANES*SAMPLE_W/8 byte enables, passed through unchanged
//  s_axis_tlast   in   1                    end of packet
//  s_axis_tvalid  in   1                    input beat valid
//  s_axis_tready  out  1                    block can accept a beat
//  bWeight        in   WEIGHT_W             weight request, sampled at packet start
//  m_axis_tdata   out  NUM_LANES*SAMPLE_W   scaled samples
//  m_axis_tkeep   out  NUM_LANES*SAMPLE_W/8 delayed s_axis_tkeep
//  m_axis_tlast   out  1                    delayed s_axis_tlast
//  m_axis_tvalid  out  1                    output beat valid
//  m_axis_tready  in   1                    downstream ready
//  active_weight  out  WEIGHT_W             weight applied to the current packet
//  pkt_count      out  16                   packets completed on output (tlast handshakes)
// BEHAVIOUR
//  Reset (RESETN low, async): all valids 0, m_axis_tdata/tkeep/tlast 0, active_weight 0,
//   pkt_count 0, in_pkt 0. Reset mid-packet discards all in-flight beats.
//  Pipeline: S1 = product register, S2 = rounded/scaled output register (drives m_axis_*).
//   adv = !m_axis_tvalid || m_axis_tready; both stages shift when adv, otherwise hold.
//   s_axis_tready = adv (combinational, registered-stage based); no beat lost or duplicated.
//   Latency: accepted beat appears on m_axis 2 cycles later with no stall; throughput 1/clk.
//  Weight capture: in_pkt flag; on accept with in_pkt=0, active_weight <= bWeight and that
//   beat uses the new value; in_pkt <= !tlast on every accept. bWeight changes mid-packet
//   take effect from the next packet. Single-beat packet (tlast on first beat) captures too.
//  Arithmetic per lane: p = $signed(sample) * $signed(w), SAMPLE_W+WEIGHT_W bits;
//   r = (p + 2^(WEIGHT_W-2)) >>> (WEIGHT_W-1) (arithmetic, round half toward +inf);
//   out = r[SAMPLE_W-1:0] subject to overflow handling below. Only overflow case:
//   sample = min, weight = min (-1.0 * -1.0 = +1.0).
//  tkeep/tlast travel alongside data through both stages; lanes with tkeep=0 still computed.
//  pkt_count increments on m_axis_tvalid & m_axis_tready & m_axis_tlast; wraps 0xFFFF -> 0.
//  Simultaneous output pop and input accept: both happen same cycle, pipeline stays full.
// CONFIGURATION
//  AXIS_WEIGHT_MULT_SAT_EN defined: r clamped to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1].
//  Not defined: r truncated to SAMPLE_W bits (two's-complement wrap), no clamp logic.
// TESTING (NUM_LANES=16, SAMPLE_W=8, WEIGHT_W=8)
//  1 bWeight=0x40, all lanes 100, tlast=1, tready=1 -> all lanes 50 (0x32) 2 cycles after accept.
//  2 bWeight=0x40, lane0=-3, lane1=3 -> lane0=-1 (0xFF), lane1=2; tkeep=0x00FF passed unchanged.
//  3 bWeight=0x80, all lanes -128 -> SAT_EN: 127 (0x7F); without macro: -128 (0x80).
//  4 4-beat packet w=0x40, bWeight->0x20 after beat 1 -> all 4 beats scaled 0.5; next packet
//    scaled 0.25; active_weight reads 0x40 then 0x20; pkt_count 1 then 2.
//  5 Random m_axis_tready (50%), 200 beats continuous input -> output sequence matches
//    model beat-for-beat, no drop/dup, s_axis_tready low only while m_axis_tvalid & !tready.
//  6 RESETN pulsed low mid-packet with 2 beats in flight -> m_axis_tvalid 0 immediately,
//    pkt_count 0, next accepted beat recaptures bWeight.

Source files
------------

// File: rtl/axis_weight_mult_pipe.sv
// axis_weight_mult_pipe: scales every lane of an AXI-Stream beat by a per-packet signed Q1.(WEIGHT_W-1) weight.
// Latency 2 cycles (S1 product register, S2 rounded output register); one beat per clock with no stall.
// Backpressure: both stages advance only while the output register is empty or being popped; s_axis_tready = that.
// Ports: CLK / RESETN (async, active-low); s_axis_* input stream; bWeight sampled on the first beat of each packet;
//   m_axis_* scaled output stream; active_weight = weight applied to the current packet;
//   pkt_count = tlast handshakes seen on the output (16-bit, wraps).
// Option: define AXIS_WEIGHT_MULT_SAT_EN to clamp results into the sample range instead of wrapping them.
module axis_weight_mult_pipe #(
  parameter int NUM_LANES = 16,
  parameter int SAMPLE_W  = 8,
  parameter int WEIGHT_W  = 8
) (
  input  logic                            CLK,
  input  logic                            RESETN,
  input  logic [NUM_LANES*SAMPLE_W-1:0]   s_axis_tdata,
  input  logic [NUM_LANES*SAMPLE_W/8-1:0] s_axis_tkeep,
  input  logic                            s_axis_tlast,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic [WEIGHT_W-1:0]             bWeight,
  output logic [NUM_LANES*SAMPLE_W-1:0]   m_axis_tdata,
  output logic [NUM_LANES*SAMPLE_W/8-1:0] m_axis_tkeep,
  output logic                            m_axis_tlast,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [WEIGHT_W-1:0]             active_weight,
  output logic [15:0]                     pkt_count
);

  localparam int DATA_W = NUM_LANES * SAMPLE_W;
  localparam int KEEP_W = DATA_W / 8;
  localparam int PROD_W = SAMPLE_W + WEIGHT_W;

  // Half an LSB of the scaled result: adding it before the arithmetic shift rounds half toward +inf.
  localparam logic signed [PROD_W-1:0] RND = PROD_W'(1 << (WEIGHT_W - 2));

  logic                        adv;
  logic                        accept;
  logic                        in_pkt;
  logic [WEIGHT_W-1:0]         cur_weight;

  logic                        s1_vld;
  logic                        s1_last;
  logic [KEEP_W-1:0]           s1_keep;
  logic [NUM_LANES*PROD_W-1:0] s1_prod;

  logic [NUM_LANES*PROD_W-1:0] prod_nxt;
  logic [DATA_W-1:0]           out_nxt;

  logic signed [PROD_W-1:0]    smp;
  logic signed [PROD_W-1:0]    wgt;
  logic signed [PROD_W-1:0]    prod_k;

  // The whole pipe moves as one: the output register is free or being drained this cycle.
  assign adv           = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = adv;
  assign accept        = s_axis_tvalid && adv;

  // The first beat of a packet must already use the weight it is capturing.
  assign cur_weight = in_pkt ? active_weight : bWeight;

  // Weight capture: latched on the first accepted beat of each packet, held until tlast is accepted.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      in_pkt        <= 1'b0;
      active_weight <= '0;
    end else if (accept) begin
      if (!in_pkt) begin
        active_weight <= bWeight;
      end
      in_pkt <= !s_axis_tlast;
    end
  end

  // Full-precision signed products, one per lane. The PROD_W-bit result cannot overflow.
  always_comb begin
    prod_nxt = '0;
    smp      = '0;
    wgt      = PROD_W'($signed(cur_weight));
    for (int k = 0; k < NUM_LANES; k++) begin
      smp = PROD_W'($signed(s_axis_tdata[k*SAMPLE_W +: SAMPLE_W]));
      prod_nxt[k*PROD_W +: PROD_W] = smp * wgt;
    end
  end

`ifdef AXIS_WEIGHT_MULT_SAT_EN
  localparam logic signed [PROD_W-1:0] R_MAX = PROD_W'((1 << (SAMPLE_W - 1)) - 1);
  localparam logic signed [PROD_W-1:0] R_MIN = PROD_W'(-(1 << (SAMPLE_W - 1)));

  logic signed [PROD_W-1:0] rnd_k;

  // Round, rescale, then clamp. Only min*min can exceed the range (+1.0 is not representable).
  always_comb begin
    out_nxt = '0;
    prod_k  = '0;
    rnd_k   = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      prod_k = $signed(s1_prod[k*PROD_W +: PROD_W]);
      rnd_k  = (prod_k + RND) >>> (WEIGHT_W - 1);
      if (rnd_k > R_MAX) begin
        out_nxt[k*SAMPLE_W +: SAMPLE_W] = R_MAX[SAMPLE_W-1:0];
      end else if (rnd_k < R_MIN) begin
        out_nxt[k*SAMPLE_W +: SAMPLE_W] = R_MIN[SAMPLE_W-1:0];
      end else begin
        out_nxt[k*SAMPLE_W +: SAMPLE_W] = rnd_k[SAMPLE_W-1:0];
      end
    end
  end
`else
  // Round and rescale; out-of-range results wrap in two's complement.
  always_comb begin
    out_nxt = '0;
    prod_k  = '0;
    for (int k = 0; k < NUM_LANES; k++) begin
      prod_k = $signed(s1_prod[k*PROD_W +: PROD_W]);
      out_nxt[k*SAMPLE_W +: SAMPLE_W] = SAMPLE_W'((prod_k + RND) >>> (WEIGHT_W - 1));
    end
  end
`endif

  // S1 (products) and S2 (output) shift together; tkeep/tlast ride alongside the data.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      s1_vld        <= 1'b0;
      s1_prod       <= '0;
      s1_keep       <= '0;
      s1_last       <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
    end else if (adv) begin
      s1_vld        <= s_axis_tvalid;
      s1_prod       <= prod_nxt;
      s1_keep       <= s_axis_tkeep;
      s1_last       <= s_axis_tlast;
      m_axis_tvalid <= s1_vld;
      m_axis_tdata  <= out_nxt;
      m_axis_tkeep  <= s1_keep;
      m_axis_tlast  <= s1_last;
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      pkt_count <= '0;
    end else if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
      pkt_count <= pkt_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_axis_weight_mult_pipe.sv
// tb_axis_weight_mult_pipe: directed and randomized stimulus for axis_weight_mult_pipe (16 lanes, 8-bit samples/weights).
// Outputs are compared against an arithmetic reference model and a queue of expected beats.
// Downstream ready is randomized in the stress phase to exercise backpressure.
module tb_axis_weight_mult_pipe;

  logic         CLK;
  logic         RESETN;
  logic [127:0] s_axis_tdata;
  logic [15:0]  s_axis_tkeep;
  logic         s_axis_tlast;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic [7:0]   bWeight;
  logic [127:0] m_axis_tdata;
  logic [15:0]  m_axis_tkeep;
  logic         m_axis_tlast;
  logic         m_axis_tvalid;
  logic         m_axis_tready;
  logic [7:0]   active_weight;
  logic [15:0]  pkt_count;

  axis_weight_mult_pipe #(.NUM_LANES(16), .SAMPLE_W(8), .WEIGHT_W(8)) dut (
    .CLK           (CLK),
    .RESETN        (RESETN),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .bWeight       (bWeight),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .active_weight (active_weight),
    .pkt_count     (pkt_count)
  );

  typedef struct {
    logic [127:0] d;
    logic [15:0]  k;
    logic         l;
  } beat_t;

  beat_t exp_q[$];
  beat_t obs_q[$];

  int          n_chk  = 0;
  int          n_pass = 0;
  int          n_out  = 0;
  logic        rand_rdy = 1'b0;
  logic        m_in_pkt = 1'b0;
  logic [7:0]  m_w      = 8'h00;
  logic [15:0] m_pkts   = 16'h0000;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference: real product of sample and weight (weight/128), rounded half up to an integer.
  function automatic logic [7:0] model_lane(input logic [7:0] s, input logic [7:0] w);
    int p;
    int num;
    int r;
    p   = $signed(s) * $signed(w);
    num = p + 64;
    if (num >= 0) r = num / 128;
    else          r = -((-num + 127) / 128);
`ifdef AXIS_WEIGHT_MULT_SAT_EN
    if (r > 127)  r = 127;
    if (r < -128) r = -128;
`endif
    return 8'(r);
  endfunction

  function automatic logic [127:0] model_data(input logic [127:0] d, input logic [7:0] w);
    logic [127:0] r;
    r = '0;
    for (int k = 0; k < 16; k++) r[k*8 +: 8] = model_lane(d[k*8 +: 8], w);
    return r;
  endfunction

  // Scoreboard / monitor. At the falling edge the inputs are stable, so a handshake seen here
  // happens at the next rising edge; DUT state seen here reflects all earlier handshakes.
  always @(negedge CLK) begin
    if (!RESETN) begin
      exp_q.delete();
      m_in_pkt = 1'b0;
      m_w      = 8'h00;
      m_pkts   = 16'h0000;
    end else begin
      chk("tready_rule", s_axis_tready, !m_axis_tvalid || m_axis_tready);
      chk("active_weight", active_weight, m_w);
      chk("pkt_count", pkt_count, m_pkts);
      if (m_axis_tvalid && m_axis_tready) begin
        beat_t ob;
        ob.d = m_axis_tdata;
        ob.k = m_axis_tkeep;
        ob.l = m_axis_tlast;
        obs_q.push_back(ob);
        n_out++;
        if (exp_q.size() == 0) begin
          chk("exp_q_size", exp_q.size(), 1);
        end else begin
          beat_t eb;
          eb = exp_q.pop_front();
          chk("sb_data", m_axis_tdata, eb.d);
          chk("sb_keep", m_axis_tkeep, eb.k);
          chk("sb_last", m_axis_tlast, eb.l);
        end
        if (m_axis_tlast) m_pkts = m_pkts + 16'd1;
      end
      if (s_axis_tvalid && s_axis_tready) begin
        beat_t nb;
        if (!m_in_pkt) m_w = bWeight;
        m_in_pkt = !s_axis_tlast;
        nb.d = model_data(s_axis_tdata, m_w);
        nb.k = s_axis_tkeep;
        nb.l = s_axis_tlast;
        exp_q.push_back(nb);
      end
    end
  end

  initial begin
    forever begin
      @(posedge CLK);
      #1;
      if (rand_rdy) m_axis_tready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Presents one beat and returns 1 time unit after the rising edge that accepts it.
  task automatic send(input logic [127:0] d, input logic [15:0] k, input logic l, input logic [7:0] w);
    logic ok;
    ok = 1'b0;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    bWeight       = w;
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge CLK);
      if (s_axis_tready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("send_timeout", ok, 1'b1);
    @(posedge CLK);
    #1;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic do_reset();
    RESETN = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    RESETN = 1'b1;
  endtask

  logic [127:0] d100, d50, d25, d_neg, e_neg, d_min, e_min;
  beat_t        b;
  int           base_out;

  initial begin
    RESETN        = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tlast  = 1'b0;
    s_axis_tvalid = 1'b0;
    bWeight       = 8'h00;
    m_axis_tready = 1'b1;
    d100  = {16{8'h64}};
    d50   = {16{8'h32}};
    d25   = {16{8'h19}};
    d_min = {16{8'h80}};
`ifdef AXIS_WEIGHT_MULT_SAT_EN
    e_min = {16{8'h7F}};
`else
    e_min = {16{8'h80}};
`endif
    d_neg = '0;
    d_neg[7:0]  = 8'hFD;
    d_neg[15:8] = 8'h03;
    e_neg = '0;
    e_neg[7:0]  = 8'hFF;
    e_neg[15:8] = 8'h02;

    // Reset state
    #12;
    chk("rst_tvalid", m_axis_tvalid, 1'b0);
    chk("rst_tdata", m_axis_tdata, 128'h0);
    chk("rst_tkeep", m_axis_tkeep, 16'h0);
    chk("rst_tlast", m_axis_tlast, 1'b0);
    chk("rst_aw", active_weight, 8'h00);
    chk("rst_pkt", pkt_count, 16'h0);
    do_reset();

    // 1: +0.5 on 100, two-cycle latency
    obs_q.delete();
    send(d100, 16'hFFFF, 1'b1, 8'h40);
    @(negedge CLK);
    chk("t1_lat_early", m_axis_tvalid, 1'b0);
    @(negedge CLK);
    chk("t1_lat_vld", m_axis_tvalid, 1'b1);
    chk("t1_data", m_axis_tdata, d50);
    idle(2);

    // 2: round half up on +-1.5, tkeep passthrough
    obs_q.delete();
    send(d_neg, 16'h00FF, 1'b1, 8'h40);
    idle(4);
    chk("t2_n", obs_q.size(), 1);
    if (obs_q.size() > 0) begin
      b = obs_q.pop_front();
      chk("t2_data", b.d, e_neg);
      chk("t2_keep", b.k, 16'h00FF);
    end

    // 3: -1.0 * -1.0 overflow case
    obs_q.delete();
    send(d_min, 16'hFFFF, 1'b1, 8'h80);
    idle(4);
    chk("t3_n", obs_q.size(), 1);
    if (obs_q.size() > 0) begin
      b = obs_q.pop_front();
      chk("t3_data", b.d, e_min);
    end

    // 4: weight held for a whole packet, new one taken on the next
    do_reset();
    obs_q.delete();
    send(d100, 16'hFFFF, 1'b0, 8'h40);
    send(d100, 16'hFFFF, 1'b0, 8'h20);
    send(d100, 16'hFFFF, 1'b0, 8'h20);
    send(d100, 16'hFFFF, 1'b1, 8'h20);
    idle(4);
    chk("t4_aw1", active_weight, 8'h40);
    chk("t4_pkt1", pkt_count, 16'd1);
    send(d100, 16'hFFFF, 1'b1, 8'h20);
    idle(4);
    chk("t4_aw2", active_weight, 8'h20);
    chk("t4_pkt2", pkt_count, 16'd2);
    chk("t4_n", obs_q.size(), 5);
    for (int i = 0; i < 5 && obs_q.size() > 0; i++) begin
      b = obs_q.pop_front();
      chk($sformatf("t4_data%0d", i), b.d, (i < 4) ? d50 : d25);
      chk($sformatf("t4_last%0d", i), b.l, (i >= 3));
    end

    // 5: randomized data/weights/packet lengths under random backpressure
    base_out = n_out;
    rand_rdy = 1'b1;
    for (int i = 0; i < 200; i++) begin
      send({$urandom, $urandom, $urandom, $urandom}, 16'($urandom),
           ($urandom_range(0, 3) == 0), 8'($urandom));
    end
    for (int i = 0; i < 1000; i++) begin
      @(negedge CLK);
      if (exp_q.size() == 0) break;
    end
    rand_rdy = 1'b0;
    m_axis_tready = 1'b1;
    idle(2);
    chk("t5_drained", exp_q.size(), 0);
    chk("t5_beats", n_out - base_out, 200);

    // 6: reset with two beats of an open packet in flight
    send(d100, 16'hFFFF, 1'b0, 8'h40);
    send(d100, 16'hFFFF, 1'b0, 8'h40);
    #2;
    RESETN = 1'b0;
    #1;
    chk("t6_vld", m_axis_tvalid, 1'b0);
    chk("t6_pkt", pkt_count, 16'h0);
    chk("t6_aw", active_weight, 8'h00);
    repeat (2) @(posedge CLK);
    #1;
    RESETN = 1'b1;
    obs_q.delete();
    send(d100, 16'hFFFF, 1'b1, 8'h20);
    idle(4);
    chk("t6_recap_aw", active_weight, 8'h20);
    chk("t6_n", obs_q.size(), 1);
    if (obs_q.size() > 0) begin
      b = obs_q.pop_front();
      chk("t6_data", b.d, d25);
    end
    chk("t6_pkt_after", pkt_count, 16'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
